// File: rtl/pulse_sequencer.sv
// pulse_sequencer
//   Table-driven pulse sequencer. Walks an OUT_W-bit pattern bus through up to
//   NUM_STEPS programmable steps ({duration, pattern} per step), for one pass,
//   N passes or free-running, with explicit start/stop control.
//
// Ports
//   clk_in, rst_in   clock, synchronous active-high reset
//   cfg_we/cfg_addr  step table write strobe and index (out-of-range ignored)
//   cfg_dur          step duration in cycles (0 behaves as 1)
//   cfg_pattern      step output pattern
//   seq_len          active step count (0 or > NUM_STEPS means all), sampled on start
//   loop_count       passes to run (0 = free-running), sampled on start
//   start, stop      run control; stop wins over everything while running
//   signal_out       registered pattern output, IDLE_PATTERN when not running
//   step_index       current step (0 when idle)
//   busy             high while running
//   seq_sync         one-cycle pulse on the first cycle of step 0 of each pass
//   done             one-cycle pulse on normal completion
//
//   state | meaning
//   IDLE  | output parked at IDLE_PATTERN, waiting for start
//   RUN   | stepping through the table, timer counts down the current step
module pulse_sequencer #(
  parameter int NUM_STEPS = 12,
  parameter int OUT_W = 8,
  parameter int DUR_W = 32,
  parameter logic [OUT_W-1:0] IDLE_PATTERN = OUT_W'(8'h80)
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           cfg_we,
  input  logic [$clog2(NUM_STEPS)-1:0]   cfg_addr,
  input  logic [DUR_W-1:0]               cfg_dur,
  input  logic [OUT_W-1:0]               cfg_pattern,
  input  logic [$clog2(NUM_STEPS):0]     seq_len,
  input  logic [15:0]                    loop_count,
  input  logic                           start,
  input  logic                           stop,
  output logic [OUT_W-1:0]               signal_out,
  output logic [$clog2(NUM_STEPS)-1:0]   step_index,
  output logic                           busy,
  output logic                           seq_sync,
  output logic                           done
);

  localparam int AW = $clog2(NUM_STEPS);
  localparam logic [AW:0] NUM_STEPS_W = (AW+1)'(NUM_STEPS);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state;
  logic [DUR_W-1:0] dur_mem [NUM_STEPS];
  logic [OUT_W-1:0] pat_mem [NUM_STEPS];

  logic [DUR_W-1:0] timer;
  logic [AW-1:0]    last_step;
  logic [15:0]      loops;
  logic [15:0]      pass_cnt;

  logic [AW-1:0]    len_m1;
  logic             at_last;
  logic             more_passes;
  logic [AW-1:0]    entry_idx;
  logic [DUR_W-1:0] entry_dur;
  logic [OUT_W-1:0] entry_pat;
  logic [DUR_W-1:0] entry_timer;

  // Step table has no reset: contents survive rst_in by design.
  always_ff @(posedge clk_in) begin
    if (cfg_we && ({1'b0, cfg_addr} < NUM_STEPS_W)) begin
      dur_mem[cfg_addr] <= cfg_dur;
      pat_mem[cfg_addr] <= cfg_pattern;
    end
  end

  always_comb begin
    if (seq_len == '0 || seq_len > NUM_STEPS_W) begin
      len_m1 = AW'(NUM_STEPS - 1);
    end else begin
      len_m1 = AW'(seq_len - (AW+1)'(1));
    end
  end

  assign at_last     = (step_index == last_step);
  assign more_passes = (loops == 16'd0) || (pass_cnt < loops);

  // The step about to be entered: step 0 on start or pass wrap, else step+1.
  // The table is read at entry time, so later writes only affect later entries.
  assign entry_idx   = (state == ST_IDLE || at_last) ? '0 : step_index + AW'(1);
  assign entry_dur   = dur_mem[entry_idx];
  assign entry_pat   = pat_mem[entry_idx];
  // Timer holds remaining cycles after the current one; dur 0 acts like 1.
  assign entry_timer = (entry_dur == '0) ? '0 : entry_dur - DUR_W'(1);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= ST_IDLE;
      signal_out <= IDLE_PATTERN;
      step_index <= '0;
      busy       <= 1'b0;
      seq_sync   <= 1'b0;
      done       <= 1'b0;
      timer      <= '0;
      last_step  <= '0;
      loops      <= '0;
      pass_cnt   <= '0;
    end else begin
      seq_sync <= 1'b0;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            state      <= ST_RUN;
            busy       <= 1'b1;
            seq_sync   <= 1'b1;
            step_index <= entry_idx;
            signal_out <= entry_pat;
            timer      <= entry_timer;
            last_step  <= len_m1;
            loops      <= loop_count;
            pass_cnt   <= 16'd1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            signal_out <= IDLE_PATTERN;
            step_index <= '0;
          end else if (timer != '0) begin
            timer <= timer - DUR_W'(1);
          end else if (!at_last || more_passes) begin
            step_index <= entry_idx;
            signal_out <= entry_pat;
            timer      <= entry_timer;
            if (at_last) begin
              seq_sync <= 1'b1;
              if (pass_cnt != 16'hFFFF) begin
                pass_cnt <= pass_cnt + 16'd1;
              end
            end
          end else begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b1;
            signal_out <= IDLE_PATTERN;
            step_index <= '0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          busy       <= 1'b0;
          signal_out <= IDLE_PATTERN;
          step_index <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/pulse_sequencer.md
# pulse_sequencer

Parametrised, table-driven pulse sequencer that supersedes the fixed 12-step pulse controller. It drives an OUT_W-bit pattern bus through up to NUM_STEPS programmable steps, each with its own pattern and duration. Sequence length and repeat count are set at run time, and the block supports single-shot, N-pass and free-running modes with explicit start/stop control. It sits between the host register interface (config writes) and the pulse output drivers.

## Interface
- NUM_STEPS, 12: depth of the step table; AW = clog2(NUM_STEPS)
- OUT_W, 8: pattern/output width
- DUR_W, 32: step duration width
- IDLE_PATTERN, 8'h80 (OUT_W bits): output value when not running
- clk_in  in  1  clock
- rst_in  in  1  synchronous, active-high reset
- cfg_we  in  1  step table write strobe
- cfg_addr  in  AW  step table index
- cfg_dur  in  DUR_W  step duration in cycles
- cfg_pattern  in  OUT_W  step output pattern
- seq_len  in  AW+1  number of active steps; sampled on start
- loop_count  in  16  passes to run (0 = free-running); sampled on start
- start  in  1  begin sequence (level sampled each cycle)
- stop  in  1  abort sequence
- signal_out  out  OUT_W  registered pattern output
- step_index  out  AW  current step
- busy  out  1  high while running
- seq_sync  out  1  one-cycle pulse on entry to step 0 of every pass
- done  out  1  one-cycle pulse on normal completion

## Operation
- Step table: NUM_STEPS entries of {dur, pattern}. Written when cfg_we=1 at cfg_addr. Writes with cfg_addr ≥ NUM_STEPS are ignored. Writes are legal at any time; an entry is read when its step is entered, so a write while busy affects the next entry of that step. Contents are not cleared by reset.
- Effective length L: seq_len = 0 or seq_len > NUM_STEPS gives L = NUM_STEPS; otherwise L = seq_len.
- Effective duration: dur = 0 is treated as 1. Step k is held for max(dur_k, 1) cycles. The down-counter is DUR_W bits; there is no overflow for any dur value.
- States: IDLE, RUN.
  - IDLE → RUN: start=1 and stop=0. Latch L and loop_count, enter step 0, pass counter = 1.
  - RUN, step timer expires, step < L−1: go to step+1.
  - RUN, step timer expires, step = L−1, loop_count = 0 or pass counter < loop_count: go to step 0, increment pass counter (16-bit, saturating; unused when loop_count = 0).
  - RUN, step timer expires, step = L−1, pass counter = loop_count: go to IDLE and pulse done.
  - RUN, stop=1: go to IDLE next cycle. No done pulse. Takes priority over all else.
- start while RUN is ignored. start and stop in the same IDLE cycle leave the block in IDLE.
- Reset at any time, including mid-sequence: next cycle signal_out = IDLE_PATTERN, step_index = 0, busy = 0, seq_sync = 0, done = 0, state IDLE.

## Timing
- All outputs are registered.
- start sampled at cycle t gives, at t+1: signal_out = pattern[0], step_index = 0, busy = 1, seq_sync = 1.
- A step with effective duration D holds signal_out for exactly D consecutive cycles. The next step's pattern appears on the cycle after, with no gap cycles between steps or passes.
- seq_sync is high in the first cycle of step 0 of each pass, including the first.
- Normal completion: the cycle after the last cycle of the final step shows signal_out = IDLE_PATTERN, busy = 0, done = 1. done is high for one cycle.
- stop sampled at cycle t: at t+1 signal_out = IDLE_PATTERN and busy = 0.
- A new start is accepted in the same cycle done is high. The sequence then restarts at the following cycle with no extra idle cycle.
- Total run length = loop_count × Σ(k<L) max(dur_k, 1) cycles.

## Test plan
- Reset defaults: assert rst_in for 2 cycles, then release with no start. Required: signal_out = 8'h80, busy = 0, done = 0, seq_sync = 0 indefinitely.
- Single pass: table = {10:88, 20:80, 30:90}, seq_len = 3, loop_count = 1, pulse start. Required: 88 for 10 cycles, 80 for 20, 90 for 30, then 80 with done = 1 on cycle 61 after start.
- Zero duration and clamping: dur_1 = 0, seq_len = 15. Required: step 1 lasts 1 cycle; L = 12 steps per pass.
- Multi-pass: loop_count = 3, 2-step table with durations {2, 3}. Required: seq_sync at offsets 1, 6 and 11; done at offset 16; busy high for 15 cycles.
- Free-run and stop: loop_count = 0, run 100 cycles, then stop mid-step. Required: output is idle the next cycle, busy = 0, done never asserted. A start asserted while running is ignored.
- Live update and mid-run reset: write pattern[0] = 8'hC0 during pass 1. Required: pass 2 step 0 outputs C0. A reset asserted mid-step gives the idle state one cycle later.
